// File: rtl/roc_sched_pkg.sv
// Shared types for the RoC tick scheduler.
//   state_e  : scheduler FSM states
//   cmd_op_e : host command opcodes
//   OP_W     : width of the command opcode field
package roc_sched_pkg;

  localparam int OP_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_TICK,
    ST_SETTLE,
    ST_SNAP
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_STOP       = 2'd0,
    OP_RUN        = 2'd1,
    OP_STEP       = 2'd2,
    OP_SET_PERIOD = 2'd3
  } cmd_op_e;

endpackage

// File: rtl/roc_period_timer.sv
// Loadable down-counter shared by the WAIT and SETTLE phases.
//   i_clk, i_rst   : clock, async active-high reset
//   i_load, i_val  : load the counter with i_val (takes priority over counting)
//   o_done         : high during the last cycle of a loaded interval
// A load of N yields o_done in the N-th cycle after the load edge.
module roc_period_timer #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)              cnt <= '0;
    else if (i_load)        cnt <= i_val;
    else if (cnt != '0)     cnt <= cnt - W'(1);
  end

  assign o_done = (cnt == W'(1));

endmodule

// File: rtl/roc_tick_sched.sv
// RoC tick scheduler: issues single-cycle tick enables under host command
// (STOP / RUN / STEP N / SET_PERIOD), waits SETTLE_CYCLES after each tick,
// captures the RoC outputs and offers them on a valid/ready port. The next
// period countdown only starts once the snapshot is taken, so none is lost.
//   i_cmd_*      : command port, accepted on i_cmd_valid && o_cmd_ready
//   o_tick       : one-cycle tick enable to the RoC
//   i_roc_outputs: RoC outputs, sampled at the end of the settle window
//   o_snap_*     : snapshot handshake, o_snap_data stable while valid
//   o_tick_count : ticks issued since reset (wraps)
//   o_running    : any state other than IDLE
// All outputs decode from registered state; no input reaches an output.
module roc_tick_sched
  import roc_sched_pkg::*;
#(
  parameter int PERIOD_W       = 32,
  parameter int COUNT_W        = 32,
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEFAULT_PERIOD = 1000,
  parameter int ROC_OUTPUTS    = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [OP_W-1:0]        i_cmd_op,
  input  logic [31:0]            i_cmd_arg,
  output logic                   o_tick,
  input  logic [ROC_OUTPUTS-1:0] i_roc_outputs,
  output logic                   o_snap_valid,
  input  logic                   i_snap_ready,
  output logic [ROC_OUTPUTS-1:0] o_snap_data,
  output logic [COUNT_W-1:0]     o_tick_count,
  output logic                   o_running
);

  state_e              state;
  logic [PERIOD_W-1:0] period;
  logic [31:0]         steps_left;
  logic                step_mode;

  cmd_op_e             op;
  logic                cmd_fire, cmd_start, last_step;
  logic                tmr_load, tmr_done;
  logic [PERIOD_W-1:0] tmr_val, wait_val;

  assign op          = cmd_op_e'(i_cmd_op);
  assign o_cmd_ready = (state == ST_IDLE) || (state == ST_WAIT);
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;
  // STEP 0 is a no-op, so it neither starts nor changes mode.
  assign cmd_start   = cmd_fire && ((op == OP_RUN) || (op == OP_STEP && i_cmd_arg != '0));
  assign last_step   = step_mode && (steps_left == 32'd1);
  assign wait_val    = (period == '0) ? PERIOD_W'(1) : period;

  assign o_tick       = (state == ST_TICK);
  assign o_snap_valid = (state == ST_SNAP);
  assign o_running    = (state != ST_IDLE);

  // Timer is loaded on every entry into WAIT (from IDLE or SNAP) and once in
  // TICK for the settle window. A RUN/STEP while already in WAIT does not
  // reload, so the running countdown continues.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = wait_val;
    case (state)
      ST_IDLE: tmr_load = cmd_start;
      ST_TICK: begin
        tmr_load = 1'b1;
        tmr_val  = PERIOD_W'(SETTLE_CYCLES);
      end
      ST_SNAP: tmr_load = i_snap_ready && !last_step;
      default: ;
    endcase
  end

  roc_period_timer #(.W(PERIOD_W)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (tmr_load),
    .i_val  (tmr_val),
    .o_done (tmr_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      period       <= PERIOD_W'(DEFAULT_PERIOD);
      steps_left   <= '0;
      step_mode    <= 1'b0;
      o_snap_data  <= '0;
      o_tick_count <= '0;
    end else begin
      if (cmd_fire && op == OP_SET_PERIOD) period <= i_cmd_arg[PERIOD_W-1:0];
      if (cmd_start) begin
        step_mode <= (op == OP_STEP);
        if (op == OP_STEP) steps_left <= i_cmd_arg;
      end
      case (state)
        ST_IDLE:   if (cmd_start) state <= ST_WAIT;
        ST_WAIT: begin
          // STOP wins over a countdown expiring in the same cycle.
          if (cmd_fire && op == OP_STOP) state <= ST_IDLE;
          else if (tmr_done)             state <= ST_TICK;
        end
        ST_TICK: begin
          state        <= ST_SETTLE;
          o_tick_count <= o_tick_count + COUNT_W'(1);
        end
        ST_SETTLE: begin
          if (tmr_done) begin
            state       <= ST_SNAP;
            o_snap_data <= i_roc_outputs;
          end
        end
        ST_SNAP: begin
          if (i_snap_ready) begin
            if (step_mode) steps_left <= steps_left - 32'd1;
            state <= last_step ? ST_IDLE : ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roc_tick_sched.sv
// Self-checking bench for roc_tick_sched. The reference model is a timeline:
// it remembers the cycle number of the next scheduled tick and derives every
// expected output from where the current cycle sits relative to it.
module tb_roc_tick_sched;
  import roc_sched_pkg::*;

  localparam int S  = 2;
  localparam int RW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [1:0]    i_cmd_op = 2'd0;
  logic [31:0]   i_cmd_arg = '0;
  logic          o_tick;
  logic [RW-1:0] i_roc_outputs = '0;
  logic          o_snap_valid;
  logic          i_snap_ready = 1'b1;
  logic [RW-1:0] o_snap_data;
  logic [31:0]   o_tick_count;
  logic          o_running;

  roc_tick_sched #(
    .PERIOD_W(32), .COUNT_W(32), .SETTLE_CYCLES(S),
    .DEFAULT_PERIOD(1000), .ROC_OUTPUTS(RW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_arg(i_cmd_arg),
    .o_tick(o_tick), .i_roc_outputs(i_roc_outputs),
    .o_snap_valid(o_snap_valid), .i_snap_ready(i_snap_ready),
    .o_snap_data(o_snap_data), .o_tick_count(o_tick_count),
    .o_running(o_running)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int tick_q[$];

  // model state
  bit          m_active;
  int          m_tick_at;
  bit          m_step;
  int          m_steps;
  logic [31:0] m_period;
  logic [31:0] m_count;
  logic [RW-1:0] m_snapd;
  bit          m_fired;
  int          m_fire_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int eff(input logic [31:0] p);
    return (p == 0) ? 1 : int'(p);
  endfunction

  task automatic model_reset();
    m_active = 0; m_tick_at = 0; m_step = 0; m_steps = 0;
    m_period = 32'd1000; m_count = '0; m_snapd = '0;
  endtask

  // One clock: compare at negedge, advance the model with this cycle's
  // inputs, then return #1 after the next posedge with fresh RoC data.
  task automatic cycle();
    bit e_tick, e_snap, e_rdy;
    @(negedge i_clk);
    e_tick = m_active && (cyc == m_tick_at);
    e_snap = m_active && (cyc > m_tick_at + S);
    e_rdy  = !m_active || (cyc < m_tick_at);
    chk("tick",       o_tick,       e_tick);
    chk("snap_valid", o_snap_valid, e_snap);
    chk("cmd_ready",  o_cmd_ready,  e_rdy);
    chk("running",    o_running,    m_active);
    chk("tick_count", o_tick_count, m_count);
    chk("snap_data",  o_snap_data,  m_snapd);
    if (o_tick) tick_q.push_back(cyc);
    m_fired = 0;
    if (e_tick) m_count = m_count + 1;
    if (m_active && cyc == m_tick_at + S) m_snapd = i_roc_outputs;
    if (i_cmd_valid && e_rdy) begin
      m_fired = 1; m_fire_cyc = cyc;
      case (i_cmd_op)
        2'd0: m_active = 0;
        2'd1: begin
          m_step = 0;
          if (!m_active) begin m_active = 1; m_tick_at = cyc + eff(m_period) + 1; end
        end
        2'd2: if (i_cmd_arg != 0) begin
          m_step = 1; m_steps = int'(i_cmd_arg);
          if (!m_active) begin m_active = 1; m_tick_at = cyc + eff(m_period) + 1; end
        end
        default: m_period = i_cmd_arg;
      endcase
    end
    if (e_snap && i_snap_ready) begin
      if (m_step) m_steps--;
      if (m_step && m_steps == 0) m_active = 0;
      else m_tick_at = cyc + eff(m_period) + 1;
    end
    cyc++;
    @(posedge i_clk); #1;
    i_roc_outputs = RW'($urandom);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
    bit ok = 0;
    i_cmd_valid = 1; i_cmd_op = op; i_cmd_arg = arg;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (m_fired) begin ok = 1; break; end
    end
    if (!ok) chk("cmd_accept_timeout", 0, 1);
    i_cmd_valid = 0;
  endtask

  task automatic wait_ticks(input int target, input int budget);
    for (int i = 0; i < budget && tick_q.size() < target; i++) cycle();
    if (tick_q.size() < target) chk("tick_timeout", tick_q.size(), target);
  endtask

  task automatic wait_snap(input int budget);
    for (int i = 0; i < budget && !o_snap_valid; i++) cycle();
    if (!o_snap_valid) chk("snap_timeout", 0, 1);
  endtask

  // Entered and left at posedge+1; reset is raised mid-cycle and the
  // outputs are checked before any further clock edge.
  task automatic do_reset();
    #3 i_rst = 1;
    #1;
    chk("rst_tick",       o_tick,       0);
    chk("rst_snap_valid", o_snap_valid, 0);
    chk("rst_snap_data",  o_snap_data,  0);
    chk("rst_tick_count", o_tick_count, 0);
    chk("rst_cmd_ready",  o_cmd_ready,  1);
    chk("rst_running",    o_running,    0);
    model_reset();
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 0;
  endtask

  initial begin
    int c;
    logic [RW-1:0] d0;
    model_reset();
    @(posedge i_clk); #1;
    do_reset();

    // STEP 3 at period 3: ticks at c+4, c+11, c+18, then idle
    send_cmd(2'd3, 32'd3);
    tick_q.delete();
    send_cmd(2'd2, 32'd3);
    c = m_fire_cyc;
    repeat (30) cycle();
    chk("step3_ntick", tick_q.size(), 3);
    if (tick_q.size() == 3) begin
      chk("step3_t0", tick_q[0] - c, 4);
      chk("step3_t1", tick_q[1] - c, 11);
      chk("step3_t2", tick_q[2] - c, 18);
    end
    chk("step3_count",   o_tick_count, 3);
    chk("step3_running", o_running,    0);

    // back-pressure: 5 extra ready-low cycles in SNAP stretch 7 -> 12
    tick_q.delete();
    i_snap_ready = 0;
    send_cmd(2'd1, 0);
    wait_ticks(1, 20);
    wait_snap(20);
    d0 = o_snap_data;
    repeat (5) cycle();
    chk("bp_valid_held", o_snap_valid, 1);
    chk("bp_data_held",  o_snap_data,  d0);
    i_snap_ready = 1;
    wait_ticks(2, 40);
    if (tick_q.size() >= 2) chk("bp_interval", tick_q[1] - tick_q[0], 12);

    // STOP presented in SETTLE stalls until the first WAIT cycle (tick+4)
    send_cmd(2'd0, 0);
    if (tick_q.size() >= 2) chk("stop_settle_accept", m_fire_cyc - tick_q[1], 4);
    chk("stop_settle_idle", o_running, 0);

    // STOP in WAIT: idle next cycle, no more ticks
    tick_q.delete();
    send_cmd(2'd1, 0);
    cycle();
    send_cmd(2'd0, 0);
    chk("stop_wait_idle", o_running, 0);
    repeat (20) cycle();
    chk("stop_wait_no_tick", tick_q.size(), 0);

    // period 0 behaves as 1: interval S+3
    tick_q.delete();
    send_cmd(2'd3, 0);
    send_cmd(2'd1, 0);
    wait_ticks(3, 60);
    if (tick_q.size() >= 3) begin
      chk("p0_interval_a", tick_q[1] - tick_q[0], 5);
      chk("p0_interval_b", tick_q[2] - tick_q[1], 5);
    end
    send_cmd(2'd0, 0);

    // SET_PERIOD 10 during WAIT: current interval 7, next 14
    send_cmd(2'd3, 32'd3);
    tick_q.delete();
    send_cmd(2'd1, 0);
    wait_ticks(1, 20);
    send_cmd(2'd3, 32'd10);
    wait_ticks(3, 80);
    if (tick_q.size() >= 3) begin
      chk("setp_cur_interval",  tick_q[1] - tick_q[0], 7);
      chk("setp_next_interval", tick_q[2] - tick_q[1], 14);
    end
    send_cmd(2'd0, 0);

    // async reset while a snapshot is pending, then STEP 0 stays idle
    send_cmd(2'd3, 32'd2);
    i_snap_ready = 0;
    send_cmd(2'd1, 0);
    wait_snap(30);
    do_reset();
    i_snap_ready = 1;
    send_cmd(2'd2, 32'd0);
    repeat (5) cycle();
    chk("step0_running", o_running,    0);
    chk("step0_count",   o_tick_count, 0);

    // randomized commands and back-pressure against the model
    send_cmd(2'd3, 32'd2);
    for (int i = 0; i < 3000; i++) begin
      i_cmd_valid  = ($urandom_range(0, 5) == 0);
      i_cmd_op     = 2'($urandom_range(0, 3));
      i_cmd_arg    = (i_cmd_op == 2'd2) ? 32'($urandom_range(0, 3)) :
                     (i_cmd_op == 2'd3) ? 32'($urandom_range(0, 5)) : $urandom;
      i_snap_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    i_cmd_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/roc_tick_sched.md
# roc_tick_sched

Tick scheduler for the RoC datapath. It replaces the free-running divided tick clock with a single-clock tick-enable pulse, and sequences RoC evaluation under host command: free-run, step N ticks, stop, or set the tick period. After every tick it waits a fixed settle time, captures a snapshot of the RoC outputs, and hands it to the command controller with a valid/ready handshake. The handshake back-pressures the next tick, so no snapshot is ever lost.

## Interface
- PERIOD_W, 32: width of the period register and the wait counter.
- COUNT_W, 32: width of the lifetime tick counter.
- SETTLE_CYCLES, 2: cycles between the tick pulse and snapshot capture; must be ≥ 1.
- DEFAULT_PERIOD, 1000: period register value after reset.
- ROC_OUTPUTS, 8: RoC output width.

- Clock and reset: one clock, `i_clk`; reset `i_rst` is asynchronous and active-high.
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_cmd_valid  in  1  command strobe
- o_cmd_ready  out  1  command accepted when valid && ready
- i_cmd_op  in  2  0 STOP, 1 RUN, 2 STEP, 3 SET_PERIOD
- i_cmd_arg  in  32  STEP count or period, truncated to PERIOD_W for SET_PERIOD
- o_tick  out  1  one-cycle tick enable to RoC
- i_roc_outputs  in  ROC_OUTPUTS  RoC outputs
- o_snap_valid  out  1  snapshot available
- i_snap_ready  in  1  consumer accepts snapshot
- o_snap_data  out  ROC_OUTPUTS  captured outputs, stable while valid
- o_tick_count  out  COUNT_W  ticks issued since reset
- o_running  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: no ticks issued.
  - WAIT: counting down the period.
  - TICK: o_tick=1 for exactly one cycle.
  - SETTLE: counting SETTLE_CYCLES.
  - SNAP: o_snap_valid=1.
- o_cmd_ready = 1 in IDLE and WAIT, 0 in TICK, SETTLE and SNAP. A command presented during those three states stalls until ready rises.
- RUN: mode becomes free-run; IDLE→WAIT with the counter loaded. If already in WAIT, the mode is replaced and the countdown continues.
- STEP N: mode becomes step with steps_left=N; IDLE→WAIT as for RUN. N=0 is accepted as a no-op (no state or mode change).
- STOP: WAIT→IDLE; no-op in IDLE.
- SET_PERIOD P: period register ← P. No state change. It takes effect at the next WAIT load; a countdown already in progress is not reloaded.
- Period 0 is treated as 1.
- WAIT → TICK after max(period,1) cycles.
- TICK → SETTLE.
- SETTLE → SNAP after SETTLE_CYCLES cycles.
- Snapshot capture: o_snap_data ← i_roc_outputs on the clock edge that ends the last SETTLE cycle.
- SNAP exit on valid && ready:
  - Step mode: steps_left decrements on leaving SNAP; at 0 → IDLE, else → WAIT.
  - Free-run: → WAIT.
- o_tick_count increments in the TICK cycle and wraps modulo 2^COUNT_W. Only reset clears it.
- Reset values: state IDLE, o_tick 0, o_snap_valid 0, o_snap_data 0, o_tick_count 0, period DEFAULT_PERIOD, steps_left 0, o_cmd_ready 1, o_running 0.
- Reset mid-operation aborts immediately. No partial tick or snapshot survives.

## Timing
- All outputs are registered or decoded from registered state only. No input→output combinational path exists except o_cmd_ready, which is decoded from state only.
- Command accepted at cycle c, from IDLE:
  - WAIT occupies c+1 … c+P.
  - o_tick is high at c+P+1.
  - SETTLE occupies c+P+2 … c+P+1+S.
  - o_snap_valid rises at c+P+S+2.
- Tick-to-tick interval with i_snap_ready held high is P+S+2 cycles. Each cycle of ready-low in SNAP adds one cycle.
- o_snap_data does not change while o_snap_valid=1.

## Structure
- Package roc_sched_pkg holds:
  - the state enum;
  - the command-op enum (STOP/RUN/STEP/SET_PERIOD);
  - the op field width constant.
- Sub-module roc_period_timer: a loadable down-counter with load and done signals, reused for WAIT and SETTLE. SETTLE is loaded with SETTLE_CYCLES.
- Top-level integration: o_tick enables RoC registers, which are clocked from i_clk. The command controller drives the cmd port and consumes snapshots.

## Test plan
- Reset: assert i_rst mid-cycle → all outputs take their reset values asynchronously; o_cmd_ready=1.
- STEP 3, period 3, S=2, ready held high → o_tick at c+4, c+11, c+18; three snapshots, each equal to the RoC outputs 2 cycles after its tick; then IDLE; o_tick_count=3.
- Back-pressure: during RUN, hold i_snap_ready low for 5 cycles in SNAP → o_snap_valid and o_snap_data hold stable; next tick is delayed by exactly 5 cycles (interval 12).
- STOP in WAIT → IDLE next cycle, no further ticks. STOP presented during SETTLE → held un-accepted until WAIT, then accepted.
- SET_PERIOD 0, then RUN → ticks every S+3=5 cycles. SET_PERIOD 10 mid-WAIT → current interval unchanged, next interval 14.
- Async reset asserted in SNAP → o_snap_valid drops without a clock edge; o_tick_count=0; STEP 0 afterwards leaves state IDLE.
